// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the register file and its write-side buffer.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_writeback_buffer_if.sv
// Result-bus, register-file write-port and bypass lookup signals of the writeback buffer.
interface rf_writeback_buffer_if
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH = REG_DATA_W,
  parameter int DEPTH      = 4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_data;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  rf_gnt;

  logic [ADDR_WIDTH-1:0] lk_addr1;
  logic [ADDR_WIDTH-1:0] lk_addr2;
  logic                  lk_hit1;
  logic                  lk_hit2;
  logic [DATA_WIDTH-1:0] lk_data1;
  logic [DATA_WIDTH-1:0] lk_data2;

  logic [CNT_W-1:0]      count;

  // Producer / register-file side.
  modport master (
    output in_valid, in_addr, in_data, rf_gnt, lk_addr1, lk_addr2,
    input  in_ready, rf_wen, rf_waddr, rf_wdata,
    input  lk_hit1, lk_hit2, lk_data1, lk_data2, count
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_addr, in_data, rf_gnt, lk_addr1, lk_addr2,
    output in_ready, rf_wen, rf_waddr, rf_wdata,
    output lk_hit1, lk_hit2, lk_data1, lk_data2, count
  );

endinterface

// File: rtl/rf_writeback_buffer_bypass_match.sv
// Youngest-first address match across the pending writeback entries.
module rf_bypass_match
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t [DEPTH-1:0]       entries,
  input  logic      [DEPTH-1:0]       valid,
  input  logic      [$clog2(DEPTH)-1:0] rd_ptr,
  input  logic      [REG_ADDR_W-1:0]  lk_addr,
  output logic                        hit,
  output logic      [REG_DATA_W-1:0]  data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0]      match_by_age;
  logic [REG_DATA_W-1:0] data_by_age [DEPTH];

  // Re-order slots by age: index 0 is the head, DEPTH-1 the newest possible slot.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      logic [PTR_W-1:0] slot;
      assign slot             = rd_ptr + PTR_W'(gi);
      assign match_by_age[gi] = valid[slot] && (entries[slot].addr == lk_addr);
      assign data_by_age[gi]  = entries[slot].data;
    end
  endgenerate

  always_comb begin
    hit  = |match_by_age;
    data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match_by_age[k]) begin
        data = data_by_age[k];
      end
    end
  end

endmodule

// File: rtl/rf_writeback_buffer.sv
// Writeback FIFO in front of the register file write port, with two bypass lookups
// over the entries that are still waiting to be written.
module rf_writeback_buffer
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH = REG_DATA_W,
  parameter int DEPTH      = 4,
  parameter bit DROP_ZERO  = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  rf_writeback_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t [DEPTH-1:0] mem_reg;
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]      count_reg, count_next;

  logic full, empty, push, store, pop, zero_dest;
  logic [DEPTH-1:0] valid;

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign zero_dest = DROP_ZERO && (bus.in_addr == '0);
  assign push      = bus.in_valid && !full;
  // Writes to index 0 still complete the handshake but never occupy a slot.
  assign store     = push && !zero_dest;
  assign pop       = !empty && bus.rf_gnt;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (store) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    case ({store, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Payload needs no reset: occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_reg[wr_ptr_reg].addr <= REG_ADDR_W'(bus.in_addr);
      mem_reg[wr_ptr_reg].data <= REG_DATA_W'(bus.in_data);
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      logic [PTR_W-1:0] age;
      assign age       = PTR_W'(gi) - rd_ptr_reg;
      assign valid[gi] = (CNT_W'(age) < count_reg);
    end
  endgenerate

  assign bus.in_ready = !full;
  assign bus.count    = count_reg;
  assign bus.rf_wen   = !empty;
  assign bus.rf_waddr = empty ? '0 : ADDR_WIDTH'(mem_reg[rd_ptr_reg].addr);
  assign bus.rf_wdata = empty ? '0 : DATA_WIDTH'(mem_reg[rd_ptr_reg].data);

  logic                  hit1_raw, hit2_raw;
  logic [REG_DATA_W-1:0] data1_raw, data2_raw;
  logic                  lk1_zero, lk2_zero;

  rf_bypass_match #(.DEPTH(DEPTH)) u_match1 (
    .entries (mem_reg),
    .valid   (valid),
    .rd_ptr  (rd_ptr_reg),
    .lk_addr (REG_ADDR_W'(bus.lk_addr1)),
    .hit     (hit1_raw),
    .data    (data1_raw)
  );

  rf_bypass_match #(.DEPTH(DEPTH)) u_match2 (
    .entries (mem_reg),
    .valid   (valid),
    .rd_ptr  (rd_ptr_reg),
    .lk_addr (REG_ADDR_W'(bus.lk_addr2)),
    .hit     (hit2_raw),
    .data    (data2_raw)
  );

  assign lk1_zero     = DROP_ZERO && (bus.lk_addr1 == '0);
  assign lk2_zero     = DROP_ZERO && (bus.lk_addr2 == '0);
  assign bus.lk_hit1  = hit1_raw && !lk1_zero;
  assign bus.lk_hit2  = hit2_raw && !lk2_zero;
  assign bus.lk_data1 = lk1_zero ? '0 : DATA_WIDTH'(data1_raw);
  assign bus.lk_data2 = lk2_zero ? '0 : DATA_WIDTH'(data2_raw);

endmodule

// File: tb/tb_rf_writeback_buffer.sv
// Directed bench for rf_writeback_buffer: one task per scenario, one line per register-file write.
module tb_rf_writeback_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_writeback_buffer_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(4)) ifc ();

  rf_writeback_buffer #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(4), .DROP_ZERO(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int checks = 0;
  int errors = 0;
  logic [4:0]  log_addr [$];
  logic [31:0] log_data [$];

  // One clock: record the write the register file captures at the coming edge, then settle.
  task automatic cycle();
    @(negedge clk);
    if (ifc.rf_wen && ifc.rf_gnt) begin
      log_addr.push_back(ifc.rf_waddr);
      log_data.push_back(ifc.rf_wdata);
      $display("WRITE addr=%0d data=0x%0h count=%0d", ifc.rf_waddr, ifc.rf_wdata, ifc.count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic test_reset();
    clear_log();
    ifc.in_valid = 1'b1; ifc.in_addr = 5'd9; ifc.in_data = 32'h99; ifc.rf_gnt = 1'b0;
    cycle();
    ifc.in_valid = 1'b0; ifc.lk_addr1 = 5'd9;
    #1;
    checks++; if (ifc.count !== 3'd1) begin errors++; $display("FAIL pre_reset_count: got %0d expected 1", ifc.count); end
    checks++; if (ifc.lk_hit1 !== 1'b1 || ifc.lk_data1 !== 32'h99) begin errors++; $display("FAIL pre_reset_lookup: got hit=%0b data=0x%0h expected hit=1 data=0x99", ifc.lk_hit1, ifc.lk_data1); end
    rst_n = 1'b0;
    #1;
    checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", ifc.in_ready); end
    checks++; if (ifc.rf_wen !== 1'b0) begin errors++; $display("FAIL reset_rf_wen: got %0b expected 0", ifc.rf_wen); end
    checks++; if (ifc.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", ifc.count); end
    checks++; if (ifc.rf_waddr !== 5'd0 || ifc.rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_rf_bus: got addr=%0d data=0x%0h expected 0/0", ifc.rf_waddr, ifc.rf_wdata); end
    checks++; if (ifc.lk_hit1 !== 1'b0 || ifc.lk_data1 !== 32'd0) begin errors++; $display("FAIL reset_lookup: got hit=%0b data=0x%0h expected 0/0", ifc.lk_hit1, ifc.lk_data1); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (ifc.count !== 3'd0 || ifc.lk_hit1 !== 1'b0) begin errors++; $display("FAIL post_reset_state: got count=%0d hit=%0b expected 0/0", ifc.count, ifc.lk_hit1); end
    ifc.lk_addr1 = 5'd0;
  endtask

  task automatic test_single();
    clear_log();
    ifc.in_valid = 1'b1; ifc.in_addr = 5'd3; ifc.in_data = 32'hAA; ifc.rf_gnt = 1'b1;
    cycle();
    ifc.in_valid = 1'b0;
    checks++; if (ifc.rf_wen !== 1'b1 || ifc.rf_waddr !== 5'd3 || ifc.rf_wdata !== 32'hAA) begin errors++; $display("FAIL single_present: got wen=%0b addr=%0d data=0x%0h expected 1/3/0xaa", ifc.rf_wen, ifc.rf_waddr, ifc.rf_wdata); end
    checks++; if (ifc.count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", ifc.count); end
    cycle();
    checks++; if (ifc.rf_wen !== 1'b0 || ifc.count !== 3'd0 || ifc.rf_waddr !== 5'd0) begin errors++; $display("FAIL single_drained: got wen=%0b count=%0d addr=%0d expected 0/0/0", ifc.rf_wen, ifc.count, ifc.rf_waddr); end
    checks++; if (log_addr.size() != 1 || log_addr[0] !== 5'd3 || log_data[0] !== 32'hAA) begin errors++; $display("FAIL single_write: got %0d writes expected one write of 3/0xaa", log_addr.size()); end
    ifc.rf_gnt = 1'b0;
  endtask

  task automatic test_fill();
    clear_log();
    ifc.rf_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifc.in_valid = 1'b1; ifc.in_addr = 5'(i + 1); ifc.in_data = 32'(17 * (i + 1));
      cycle();
    end
    checks++; if (ifc.count !== 3'd4 || ifc.in_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got count=%0d ready=%0b expected 4/0", ifc.count, ifc.in_ready); end
    checks++; if (ifc.rf_waddr !== 5'd1 || ifc.rf_wdata !== 32'h11) begin errors++; $display("FAIL fill_head: got addr=%0d data=0x%0h expected 1/0x11", ifc.rf_waddr, ifc.rf_wdata); end
    ifc.in_addr = 5'd5; ifc.in_data = 32'h55;
    cycle();
    ifc.in_valid = 1'b0;
    checks++; if (ifc.count !== 3'd4) begin errors++; $display("FAIL fill_refuse: got count=%0d expected 4", ifc.count); end
    ifc.rf_gnt = 1'b1;
    repeat (4) cycle();
    ifc.rf_gnt = 1'b0;
    checks++; if (ifc.count !== 3'd0 || log_addr.size() != 4) begin errors++; $display("FAIL fill_drain: got count=%0d writes=%0d expected 0/4", ifc.count, log_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= log_addr.size() || log_addr[i] !== 5'(i + 1) || log_data[i] !== 32'(17 * (i + 1))) begin
        errors++; $display("FAIL fill_order[%0d]: got addr=%0d data=0x%0h expected %0d/0x%0h", i, log_addr[i], log_data[i], i + 1, 17 * (i + 1));
      end
    end
  endtask

  task automatic test_bypass();
    clear_log();
    ifc.rf_gnt = 1'b0;
    ifc.in_valid = 1'b1; ifc.in_addr = 5'd5; ifc.in_data = 32'h10;
    ifc.lk_addr1 = 5'd5; ifc.lk_addr2 = 5'd7;
    #1;
    checks++; if (ifc.lk_hit1 !== 1'b0) begin errors++; $display("FAIL bypass_incoming: got hit=%0b expected 0", ifc.lk_hit1); end
    cycle();
    ifc.in_addr = 5'd6; ifc.in_data = 32'h20;
    cycle();
    ifc.in_addr = 5'd5; ifc.in_data = 32'h30;
    cycle();
    ifc.in_valid = 1'b0;
    checks++; if (ifc.lk_hit1 !== 1'b1 || ifc.lk_data1 !== 32'h30) begin errors++; $display("FAIL bypass_youngest: got hit=%0b data=0x%0h expected 1/0x30", ifc.lk_hit1, ifc.lk_data1); end
    checks++; if (ifc.lk_hit2 !== 1'b0 || ifc.lk_data2 !== 32'd0) begin errors++; $display("FAIL bypass_miss: got hit=%0b data=0x%0h expected 0/0", ifc.lk_hit2, ifc.lk_data2); end
    ifc.lk_addr2 = 5'd6;
    #1;
    checks++; if (ifc.lk_hit2 !== 1'b1 || ifc.lk_data2 !== 32'h20) begin errors++; $display("FAIL bypass_middle: got hit=%0b data=0x%0h expected 1/0x20", ifc.lk_hit2, ifc.lk_data2); end
    ifc.rf_gnt = 1'b1;
    cycle();
    checks++; if (ifc.lk_hit1 !== 1'b1 || ifc.lk_data1 !== 32'h30) begin errors++; $display("FAIL bypass_after_pop: got hit=%0b data=0x%0h expected 1/0x30", ifc.lk_hit1, ifc.lk_data1); end
    checks++; if (ifc.lk_hit2 !== 1'b1 || ifc.lk_data2 !== 32'h20) begin errors++; $display("FAIL bypass_popping_head: got hit=%0b data=0x%0h expected 1/0x20", ifc.lk_hit2, ifc.lk_data2); end
    cycle();
    checks++; if (ifc.lk_hit2 !== 1'b0) begin errors++; $display("FAIL bypass_head_gone: got hit=%0b expected 0", ifc.lk_hit2); end
    cycle();
    ifc.rf_gnt = 1'b0;
    checks++; if (ifc.lk_hit1 !== 1'b0 || ifc.lk_data1 !== 32'd0 || ifc.count !== 3'd0) begin errors++; $display("FAIL bypass_empty: got hit=%0b data=0x%0h count=%0d expected 0/0/0", ifc.lk_hit1, ifc.lk_data1, ifc.count); end
    checks++; if (log_addr.size() != 3 || log_data[0] !== 32'h10 || log_addr[1] !== 5'd6 || log_data[2] !== 32'h30) begin errors++; $display("FAIL bypass_writes: got %0d writes expected 5/0x10 6/0x20 5/0x30", log_addr.size()); end
  endtask

  task automatic test_zero();
    clear_log();
    ifc.in_valid = 1'b1; ifc.in_addr = 5'd0; ifc.in_data = 32'hFF; ifc.lk_addr1 = 5'd0;
    #1;
    checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %0b expected 1", ifc.in_ready); end
    cycle();
    ifc.in_valid = 1'b0;
    checks++; if (ifc.count !== 3'd0 || ifc.rf_wen !== 1'b0) begin errors++; $display("FAIL zero_dropped: got count=%0d wen=%0b expected 0/0", ifc.count, ifc.rf_wen); end
    checks++; if (ifc.lk_hit1 !== 1'b0 || ifc.lk_data1 !== 32'd0) begin errors++; $display("FAIL zero_lookup: got hit=%0b data=0x%0h expected 0/0", ifc.lk_hit1, ifc.lk_data1); end
    ifc.rf_gnt = 1'b1;
    repeat (2) cycle();
    ifc.rf_gnt = 1'b0;
    checks++; if (log_addr.size() != 0) begin errors++; $display("FAIL zero_no_write: got %0d writes expected 0", log_addr.size()); end
  endtask

  task automatic test_full_wrap();
    int sent = 0;
    int n = 0;
    logic acc;
    clear_log();
    ifc.rf_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifc.in_valid = 1'b1; ifc.in_addr = 5'(10 + i); ifc.in_data = 32'(160 + i);
      cycle();
    end
    checks++; if (ifc.count !== 3'd4) begin errors++; $display("FAIL wrap_full: got count=%0d expected 4", ifc.count); end
    ifc.rf_gnt = 1'b1; ifc.in_addr = 5'd14; ifc.in_data = 32'hA4;
    cycle();
    checks++; if (ifc.count !== 3'd3 || ifc.in_ready !== 1'b1) begin errors++; $display("FAIL wrap_pop_refuse: got count=%0d ready=%0b expected 3/1", ifc.count, ifc.in_ready); end
    cycle();
    ifc.in_valid = 1'b0;
    checks++; if (ifc.count !== 3'd3 || ifc.rf_waddr !== 5'd12) begin errors++; $display("FAIL wrap_push_pop: got count=%0d head=%0d expected 3/12", ifc.count, ifc.rf_waddr); end
    while ((sent < 10 || ifc.count != 0) && n < 200) begin
      ifc.rf_gnt = n[0];
      if (sent < 10) begin
        ifc.in_valid = 1'b1; ifc.in_addr = 5'(16 + sent); ifc.in_data = 32'(256 + sent);
      end else begin
        ifc.in_valid = 1'b0;
      end
      acc = ifc.in_valid && ifc.in_ready;
      cycle();
      if (acc) sent++;
      n++;
    end
    ifc.in_valid = 1'b0; ifc.rf_gnt = 1'b0;
    checks++; if (n >= 200) begin errors++; $display("FAIL wrap_timeout: got sent=%0d count=%0d expected drain within 200 cycles", sent, ifc.count); end
    checks++; if (log_addr.size() != 15) begin errors++; $display("FAIL wrap_write_count: got %0d expected 15", log_addr.size()); end
    for (int i = 0; i < 15; i++) begin
      logic [4:0]  ea;
      logic [31:0] ed;
      ea = (i < 5) ? 5'(10 + i) : 5'(11 + i);
      ed = (i < 5) ? 32'(160 + i) : 32'(251 + i);
      checks++;
      if (i >= log_addr.size() || log_addr[i] !== ea || log_data[i] !== ed) begin
        errors++; $display("FAIL wrap_order[%0d]: got addr=%0d data=0x%0h expected %0d/0x%0h", i, log_addr[i], log_data[i], ea, ed);
      end
    end
  endtask

  task automatic test_reset_drain();
    clear_log();
    ifc.rf_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ifc.in_valid = 1'b1; ifc.in_addr = 5'(20 + i); ifc.in_data = 32'(192 + i);
      cycle();
    end
    ifc.in_valid = 1'b0;
    checks++; if (ifc.count !== 3'd3) begin errors++; $display("FAIL drain_pending: got count=%0d expected 3", ifc.count); end
    ifc.rf_gnt = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if (ifc.rf_wen !== 1'b0 || ifc.count !== 3'd0) begin errors++; $display("FAIL drain_reset_async: got wen=%0b count=%0d expected 0/0", ifc.rf_wen, ifc.count); end
    cycle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cycle();
    ifc.rf_gnt = 1'b0;
    checks++; if (ifc.count !== 3'd0 || ifc.rf_wen !== 1'b0) begin errors++; $display("FAIL drain_after_release: got count=%0d wen=%0b expected 0/0", ifc.count, ifc.rf_wen); end
    checks++; if (log_addr.size() != 0) begin errors++; $display("FAIL drain_no_write: got %0d writes expected 0", log_addr.size()); end
  endtask

  initial begin
    ifc.in_valid = 1'b0; ifc.in_addr = '0; ifc.in_data = '0; ifc.rf_gnt = 1'b0;
    ifc.lk_addr1 = '0; ifc.lk_addr2 = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_fill();
    test_bypass();
    test_zero();
    test_full_wrap();
    test_reset_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
